soc_system_reset_pulse_pio: RTL and testbench

Parametrised Avalon-MM output PIO driving per-channel reset/enable lines to the motor-driver boards. It provides a level register, atomic set/clear access and a self-timed reset pulse per channel, so the HPS can reset one axis without read-modify-write races or software delay loops. It sits on the lightweight HPS-to-FPGA bridge. Its outputs go to the FPGA pins that feed the driver reset inputs.

---
 rtl/soc_system_reset_pulse_pio.sv | 134 +++++++++++++
 tb/tb_soc_system_reset_pulse_pio.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_reset_pulse_pio.sv
// Avalon-MM output PIO for motor-driver reset/enable lines.
// Provides a level register, atomic set/clear and a self-timed reset pulse per
// channel, so one axis can be reset without read-modify-write races or
// software delay loops.
module soc_system_reset_pulse_pio #(
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned CNT_W             = 16,
    parameter int unsigned PULSE_LEN_DEFAULT = 1000,
    parameter bit          OUT_INVERT        = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] out_port,
    output logic              busy
);

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_SET   = 3'd1;
    localparam logic [2:0] ADDR_CLEAR = 3'd2;
    localparam logic [2:0] ADDR_PULSE = 3'd3;
    localparam logic [2:0] ADDR_LEN   = 3'd4;
    localparam logic [2:0] ADDR_INFO  = 3'd5;

    localparam logic [7:0] VERSION = 8'h01;

    logic [NUM_CH-1:0] data_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] act;
    logic [NUM_CH-1:0] pre;

    logic              wr;
    logic              wr_data;
    logic              wr_set;
    logic              wr_clr;
    logic              wr_pulse;
    logic              wr_len;
    logic [NUM_CH-1:0] wd_ch;
    logic [CNT_W-1:0]  wd_len;

    // Bits of writedata above NUM_CH / CNT_W are deliberately ignored.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    // Write strobe and per-register write decode.
    always_comb begin
        wr       = chipselect & ~write_n;
        wr_data  = 1'b0;
        wr_set   = 1'b0;
        wr_clr   = 1'b0;
        wr_pulse = 1'b0;
        wr_len   = 1'b0;
        wd_ch    = writedata[NUM_CH-1:0];
        wd_len   = writedata[CNT_W-1:0];
        if (wr) begin
            case (address)
                ADDR_DATA:  wr_data  = 1'b1;
                ADDR_SET:   wr_set   = 1'b1;
                ADDR_CLEAR: wr_clr   = 1'b1;
                ADDR_PULSE: wr_pulse = 1'b1;
                ADDR_LEN:   wr_len   = 1'b1;
                default:    ;
            endcase
        end
    end

    // Level register with plain, set and clear write paths.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (wr_data) begin
            data_q <= wd_ch;
        end else if (wr_set) begin
            data_q <= data_q | wd_ch;
        end else if (wr_clr) begin
            data_q <= data_q & ~wd_ch;
        end
    end

    // Pulse length; zero is stored as one so a pulse is never empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_q <= CNT_W'(PULSE_LEN_DEFAULT);
        end else if (wr_len) begin
            len_q <= (wd_len == '0) ? CNT_W'(1) : wd_len;
        end
    end

    // Per-channel down-counters; a retrigger reloads and so only extends.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!reset_n) begin
                cnt_q[i] <= '0;
            end else if (wr_pulse && wd_ch[i]) begin
                cnt_q[i] <= len_q;
            end else if (cnt_q[i] != '0) begin
                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Pulse-active mask, derived from counter state only.
    always_comb begin
        act = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            act[i] = (cnt_q[i] != '0);
        end
    end

    // Output drive: level OR pulse, optionally inverted for active-low pins.
    always_comb begin
        pre      = data_q | act;
        out_port = OUT_INVERT ? ~pre : pre;
        busy     = |act;
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:  readdata = 32'(data_q);
            ADDR_PULSE: readdata = 32'(act);
            ADDR_LEN:   readdata = 32'(len_q);
            ADDR_INFO:  readdata = {VERSION, 8'h00, 8'(CNT_W), 8'(NUM_CH)};
            default:    readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_system_reset_pulse_pio.sv
// Directed self-checking bench for soc_system_reset_pulse_pio.
module tb_soc_system_reset_pulse_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;
    logic        busy;
    logic [31:0] readdata_inv;
    logic [3:0]  out_port_inv;
    logic        busy_inv;

    int n_cmp;
    int n_err;

    soc_system_reset_pulse_pio u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    soc_system_reset_pulse_pio #(.OUT_INVERT(1'b1)) u_dut_inv (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_inv),
        .out_port   (out_port_inv),
        .busy       (busy_inv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Drive a write for the coming edge without waiting.
    task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
    endtask

    task automatic drive_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bus_write(3'd0, 32'hF);
        bus_write(3'd4, 32'd7);
        bus_write(3'd3, 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        bus_write(3'd0, 32'hF);   // coincides with reset, must be dropped
        reset_n = 1'b1;
        n_cmp++;
        if (out_port !== 4'h0) begin
            n_err++; $display("FAIL reset_out: got %h expected %h", out_port, 4'h0);
        end
        n_cmp++;
        if (out_port_inv !== 4'hF) begin
            n_err++; $display("FAIL reset_out_inv: got %h expected %h", out_port_inv, 4'hF);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        bus_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'd1000) begin
            n_err++; $display("FAIL reset_len: got %0d expected 1000", rd);
        end
        bus_read(3'd0, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_err++; $display("FAIL reset_data: got %h expected 0", rd);
        end
        bus_read(3'd3, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_err++; $display("FAIL reset_act: got %h expected 0", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_set_clear();
        logic [31:0] rd;
        bus_write(3'd0, 32'h5);
        n_cmp++;
        if (out_port !== 4'b0101) begin
            n_err++; $display("FAIL data_wr: got %b expected 0101", out_port);
        end
        n_cmp++;
        if (out_port_inv !== 4'b1010) begin
            n_err++; $display("FAIL data_wr_inv: got %b expected 1010", out_port_inv);
        end
        bus_write(3'd1, 32'h2);
        n_cmp++;
        if (out_port !== 4'b0111) begin
            n_err++; $display("FAIL set_wr: got %b expected 0111", out_port);
        end
        bus_write(3'd2, 32'h4);
        n_cmp++;
        if (out_port !== 4'b0011) begin
            n_err++; $display("FAIL clear_wr: got %b expected 0011", out_port);
        end
        bus_read(3'd1, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_err++; $display("FAIL set_read: got %h expected 0", rd);
        end
        bus_read(3'd2, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_err++; $display("FAIL clear_read: got %h expected 0", rd);
        end
        bus_read(3'd0, rd);
        n_cmp++;
        if (rd !== 32'h3) begin
            n_err++; $display("FAIL data_read: got %h expected 3", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_pulse();
        logic [31:0] rd;
        logic        exp;
        bus_write(3'd0, 32'h0);
        bus_write(3'd4, 32'd5);
        bus_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'd5) begin
            n_err++; $display("FAIL len_read: got %0d expected 5", rd);
        end
        @(negedge clk);
        bus_write(3'd3, 32'h8);
        for (int j = 0; j < 8; j++) begin
            exp     = (j < 5);
            address = 3'd3;
            #1;
            n_cmp++;
            if (out_port !== {exp, 3'b000}) begin
                n_err++; $display("FAIL pulse_out[%0d]: got %b expected %b", j, out_port, {exp, 3'b000});
            end
            n_cmp++;
            if (busy !== exp) begin
                n_err++; $display("FAIL pulse_busy[%0d]: got %b expected %b", j, busy, exp);
            end
            n_cmp++;
            if (readdata !== (exp ? 32'h8 : 32'h0)) begin
                n_err++; $display("FAIL pulse_act[%0d]: got %h expected %h", j, readdata, exp ? 32'h8 : 32'h0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_retrigger();
        logic [3:0] exp;
        bus_write(3'd4, 32'd10);
        for (int t = 0; t < 20; t++) begin
            exp = {2'b00, (t >= 6 && t <= 15), (t >= 1 && t <= 13)};
            n_cmp++;
            if (out_port !== exp) begin
                n_err++; $display("FAIL retrig_out[t=%0d]: got %b expected %b", t, out_port, exp);
            end
            n_cmp++;
            if (busy !== (exp != 4'h0)) begin
                n_err++; $display("FAIL retrig_busy[t=%0d]: got %b expected %b", t, busy, exp != 4'h0);
            end
            n_cmp++;
            if (out_port_inv !== ~exp) begin
                n_err++; $display("FAIL retrig_inv[t=%0d]: got %b expected %b", t, out_port_inv, ~exp);
            end
            case (t)
                0, 3:    drive_wr(3'd3, 32'h1);
                5:       drive_wr(3'd3, 32'h2);
                default: drive_idle();
            endcase
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_boundary();
        logic [31:0] rd;
        logic [3:0]  exp;
        bus_write(3'd4, 32'd0);
        bus_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'd1) begin
            n_err++; $display("FAIL len_zero: got %0d expected 1", rd);
        end
        @(negedge clk);
        bus_write(3'd3, 32'h4);
        n_cmp++;
        if (out_port !== 4'b0100) begin
            n_err++; $display("FAIL short_pulse_on: got %b expected 0100", out_port);
        end
        @(negedge clk);
        n_cmp++;
        if (out_port !== 4'b0000) begin
            n_err++; $display("FAIL short_pulse_off: got %b expected 0000", out_port);
        end
        bus_write(3'd4, 32'd10);
        // ch0: length change mid-pulse ignored; ch1: DATA set mid-pulse holds it high.
        for (int t = 0; t < 15; t++) begin
            exp = {2'b00, (t >= 1), (t >= 1 && t <= 10)};
            n_cmp++;
            if (out_port !== exp) begin
                n_err++; $display("FAIL midlen_out[t=%0d]: got %b expected %b", t, out_port, exp);
            end
            case (t)
                0:       drive_wr(3'd3, 32'h3);
                2:       drive_wr(3'd4, 32'd2);
                4:       drive_wr(3'd0, 32'h2);
                default: drive_idle();
            endcase
            @(negedge clk);
        end
        drive_idle();
        bus_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'd2) begin
            n_err++; $display("FAIL midlen_read: got %0d expected 2", rd);
        end
        @(negedge clk);
        bus_write(3'd3, 32'h8);
        for (int j = 0; j < 4; j++) begin
            exp = (j < 2) ? 4'b1010 : 4'b0010;
            n_cmp++;
            if (out_port !== exp) begin
                n_err++; $display("FAIL newlen_out[%0d]: got %b expected %b", j, out_port, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_pulse_info();
        logic [31:0] rd;
        logic        exp;
        bus_write(3'd0, 32'h0);
        bus_write(3'd4, 32'd10);
        for (int t = 0; t < 16; t++) begin
            exp = (t >= 1 && t <= 3);
            n_cmp++;
            if (out_port !== {3'b000, exp}) begin
                n_err++; $display("FAIL rstmid_out[t=%0d]: got %b expected %b", t, out_port, {3'b000, exp});
            end
            n_cmp++;
            if (busy !== exp) begin
                n_err++; $display("FAIL rstmid_busy[t=%0d]: got %b expected %b", t, busy, exp);
            end
            if (t == 0) drive_wr(3'd3, 32'h1);
            else        drive_idle();
            if (t == 3) reset_n = 1'b0;
            if (t == 4) reset_n = 1'b1;
            @(negedge clk);
        end
        bus_read(3'd5, rd);
        n_cmp++;
        if (rd !== 32'h01001004) begin
            n_err++; $display("FAIL info: got %h expected 01001004", rd);
        end
        bus_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'd1000) begin
            n_err++; $display("FAIL rstmid_len: got %0d expected 1000", rd);
        end
        @(negedge clk);
        address    = 3'd0;
        writedata  = 32'hF;
        chipselect = 1'b0;
        write_n    = 1'b0;
        @(negedge clk);
        write_n    = 1'b1;
        bus_read(3'd0, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_err++; $display("FAIL nocs_data: got %h expected 0", rd);
        end
        n_cmp++;
        if (out_port !== 4'h0) begin
            n_err++; $display("FAIL nocs_out: got %b expected 0000", out_port);
        end
        @(negedge clk);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_err++; $display("FAIL addr6_read: got %h expected 0", rd);
        end
        bus_read(3'd0, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_err++; $display("FAIL addr6_data: got %h expected 0", rd);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_set_clear();
        test_pulse();
        test_retrigger();
        test_boundary();
        test_reset_mid_pulse_info();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
